// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: a FIFO feeds a per-frame configurable serialiser
// (5-9 data bits, optional parity, 1/2 stop bits) with line-break generation.
module uart_tx_fifo #(
  parameter int unsigned MAX_DATA_BITS = 9,
  parameter int unsigned FIFO_DEPTH    = 16,
  parameter int unsigned CNT_W         = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     baud_tick,
  input  logic [MAX_DATA_BITS-1:0] wr_data,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [3:0]               cfg_data_bits,
  input  logic                     cfg_parity_en,
  input  logic                     cfg_parity_odd,
  input  logic                     cfg_stop2,
  input  logic                     brk_req,
  output logic                     data_tx,
  output logic                     active_flag,
  output logic                     done_flag,
  output logic [CNT_W-1:0]         fifo_count,
  output logic                     fifo_full,
  output logic                     fifo_empty
);

  localparam int unsigned DW = MAX_DATA_BITS;
  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  typedef struct packed {
    logic [3:0] data_bits;
    logic       parity_en;
    logic       parity_bit;
    logic       stop2;
  } frame_cfg_t;

  logic [DW-1:0]    mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [DW-1:0]    head_c;
  logic             push_c, pop_c;
  logic [CNT_W-1:0] count_nxt_c;

  state_t        state, state_nxt;
  frame_cfg_t    cfg_q, cfg_nxt;
  logic [DW-1:0] shreg, shreg_nxt;
  logic [3:0]    bit_cnt, bit_cnt_nxt;
  logic          stop_cnt, stop_cnt_nxt;
  logic          mark_q, mark_nxt;
  logic          tx_nxt, active_nxt, done_nxt;
  logic          load_c;
  logic [3:0]    bits_eff_c;
  logic          parity_c;

  assign wr_ready = !fifo_full;
  assign push_c   = wr_valid && !fifo_full;
  assign head_c   = mem[rd_ptr];

  // FIFO occupancy bookkeeping
  always_comb begin
    count_nxt_c = fifo_count;
    if (push_c && !pop_c)      count_nxt_c = fifo_count + CNT_W'(1);
    else if (pop_c && !push_c) count_nxt_c = fifo_count - CNT_W'(1);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      fifo_full  <= 1'b0;
      fifo_empty <= 1'b1;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + AW'(1);
      if (pop_c)  rd_ptr <= rd_ptr + AW'(1);
      fifo_count <= count_nxt_c;
      fifo_full  <= (count_nxt_c == CNT_W'(FIFO_DEPTH));
      fifo_empty <= (count_nxt_c == '0);
    end
  end

  always_ff @(posedge clock) begin
    if (push_c) mem[wr_ptr] <= wr_data;
  end

  // Clamp requested width into the legal 5..MAX_DATA_BITS range
  always_comb begin
    bits_eff_c = cfg_data_bits;
    if (cfg_data_bits < 4'd5)                    bits_eff_c = 4'd5;
    else if (cfg_data_bits > 4'(MAX_DATA_BITS))  bits_eff_c = 4'(MAX_DATA_BITS);
  end

  // Parity over the active data bits only, computed when the word is popped
  always_comb begin
    parity_c = cfg_parity_odd;
    for (int i = 0; i < int'(DW); i++) begin
      if (4'(i) < bits_eff_c) parity_c = parity_c ^ head_c[i];
    end
  end

  always_comb begin
    state_nxt    = state;
    cfg_nxt      = cfg_q;
    shreg_nxt    = shreg;
    bit_cnt_nxt  = bit_cnt;
    stop_cnt_nxt = stop_cnt;
    mark_nxt     = mark_q;
    tx_nxt       = data_tx;
    done_nxt     = 1'b0;
    load_c       = 1'b0;
    pop_c        = 1'b0;
    if (baud_tick) begin
      case (state)
        S_IDLE: begin
          if (brk_req) begin
            state_nxt = S_BREAK;
            tx_nxt    = 1'b0;
          end else if (!fifo_empty) begin
            load_c = 1'b1;
          end
        end
        S_START: begin
          state_nxt   = S_DATA;
          tx_nxt      = shreg[0];
          shreg_nxt   = shreg >> 1;
          bit_cnt_nxt = 4'd0;
        end
        S_DATA: begin
          if (bit_cnt == cfg_q.data_bits - 4'd1) begin
            stop_cnt_nxt = 1'b0;
            if (cfg_q.parity_en) begin
              state_nxt = S_PARITY;
              tx_nxt    = cfg_q.parity_bit;
            end else begin
              state_nxt = S_STOP;
              tx_nxt    = 1'b1;
            end
          end else begin
            tx_nxt      = shreg[0];
            shreg_nxt   = shreg >> 1;
            bit_cnt_nxt = bit_cnt + 4'd1;
          end
        end
        S_PARITY: begin
          state_nxt = S_STOP;
          tx_nxt    = 1'b1;
        end
        S_STOP: begin
          // A post-break mark is always a single period and reports no frame
          if (!mark_q && cfg_q.stop2 && !stop_cnt) begin
            stop_cnt_nxt = 1'b1;
          end else begin
            done_nxt = !mark_q;
            mark_nxt = 1'b0;
            if (brk_req) begin
              state_nxt = S_BREAK;
              tx_nxt    = 1'b0;
            end else if (!fifo_empty) begin
              load_c = 1'b1;
            end else begin
              state_nxt = S_IDLE;
            end
          end
        end
        S_BREAK: begin
          if (!brk_req) begin
            state_nxt    = S_STOP;
            tx_nxt       = 1'b1;
            mark_nxt     = 1'b1;
            stop_cnt_nxt = 1'b0;
          end
        end
        default: begin
          state_nxt = S_IDLE;
          tx_nxt    = 1'b1;
        end
      endcase
    end
    if (load_c) begin
      pop_c     = 1'b1;
      state_nxt = S_START;
      tx_nxt    = 1'b0;
      shreg_nxt = head_c;
      cfg_nxt   = '{data_bits: bits_eff_c, parity_en: cfg_parity_en,
                    parity_bit: parity_c, stop2: cfg_stop2};
    end
    active_nxt = (state_nxt != S_IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      cfg_q       <= '0;
      shreg       <= '0;
      bit_cnt     <= '0;
      stop_cnt    <= 1'b0;
      mark_q      <= 1'b0;
      data_tx     <= 1'b1;
      active_flag <= 1'b0;
      done_flag   <= 1'b0;
    end else begin
      state       <= state_nxt;
      cfg_q       <= cfg_nxt;
      shreg       <= shreg_nxt;
      bit_cnt     <= bit_cnt_nxt;
      stop_cnt    <= stop_cnt_nxt;
      mark_q      <= mark_nxt;
      data_tx     <= tx_nxt;
      active_flag <= active_nxt;
      done_flag   <= done_nxt;
    end
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered, runtime-configurable UART transmitter: the parametrised successor to the single-byte PISO transmitter. Words enter through a valid/ready write port into an internal FIFO and are serialised back-to-back with no idle gap. Frame format (5–9 data bits, parity none/even/odd, 1 or 2 stop bits) is selectable per frame, and the block can generate a line break. It sits between the host bus interface and the TX pin, and is paced by the shared one-clock `baud_tick` strobe.

## Interface
- `MAX_DATA_BITS`, 9: width of stored words; legal 5–9.
- `FIFO_DEPTH`, 16: FIFO entries; power of two, ≥2.
- `CNT_W`, `$clog2(FIFO_DEPTH+1)`: width of `fifo_count`; derived, not overridden.

Ports:
- `clock` in 1: system clock; all logic on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `baud_tick` in 1: one-clock pulse per bit period.
- `wr_data` in MAX_DATA_BITS: word to transmit, LSB sent first.
- `wr_valid` in 1: write request.
- `wr_ready` out 1: `!fifo_full`, combinational; a write is accepted when `wr_valid && wr_ready`.
- `cfg_data_bits` in 4: data bits per frame; values <5 act as 5, values >MAX_DATA_BITS act as MAX_DATA_BITS.
- `cfg_parity_en` in 1: parity bit present.
- `cfg_parity_odd` in 1: 1 = odd, 0 = even.
- `cfg_stop2` in 1: two stop bits.
- `brk_req` in 1: request line break (level).
- `data_tx` out 1: serial line, idle high.
- `active_flag` out 1: frame or break in progress.
- `done_flag` out 1: one-clock pulse at end of each frame.
- `fifo_count` out CNT_W: occupancy.
- `fifo_full` out 1, `fifo_empty` out 1: FIFO status.

## Operation
- States: IDLE, START, DATA, PARITY, STOP, BREAK. All transitions occur only on clocks where `baud_tick`=1.
- IDLE: on a tick with `brk_req`=1, go to BREAK; the break takes priority over FIFO data. Otherwise, on a tick with the FIFO non-empty:
  - pop the head word;
  - latch all four `cfg_*` inputs for the whole frame;
  - set `data_tx`=0 and go to START.
- START → DATA on the next tick; drive bit 0. DATA shifts one bit per tick, for the latched bit count D.
- After the last data bit, the next tick goes to PARITY if enabled, otherwise to STOP with `data_tx`=1.
  - Parity bit = XOR of the D LSBs, inverted if odd. Bits at or above D are ignored.
- STOP lasts 1 or 2 bit periods. On the tick that ends STOP:
  - `done_flag`=1 for that clock;
  - if `brk_req`, go to BREAK;
  - else if the FIFO is non-empty, pop and go directly to START on that same tick (back-to-back framing);
  - else go to IDLE.
- BREAK: `data_tx`=0 while `brk_req`=1. On the first tick with `brk_req`=0, set `data_tx`=1 and go to STOP for one mark period. No `done_flag` is issued after a break.
- `active_flag`=1 in every state except IDLE.
- FIFO: circular buffer with wrapping read/write pointers.
  - A push and a pop in the same clock leave the count unchanged.
  - While full, a pop raises `wr_ready` on the following clock only; a write offered in the pop clock is not accepted.
- Mid-frame `cfg_*` changes take effect from the next frame.

## Timing
- Reset values: `data_tx`=1, `active_flag`=0, `done_flag`=0, `fifo_count`=0, `fifo_empty`=1, `fifo_full`=0, `wr_ready`=1. The state returns to IDLE.
- Reset mid-frame: the line goes high immediately (asynchronous) and FIFO contents are discarded.
- Write accepted at clock N: `fifo_count`/`fifo_empty` update at N+1. The frame starts on the first tick at or after N+1.
- Frame length = 1 + D + P + S bit periods. Consecutive frames have zero idle ticks between them.
- `done_flag` coincides with the clock on which the final stop period ends.

## Test plan
- 8N1, write 0xA5 → line shows 0,1,0,1,0,0,1,0,1,1 at successive ticks; one `done_flag` pulse; `active_flag` high for exactly 10 tick periods.
- 8E1 with 0xA5 → parity bit 0. 8O1 with 0xA5 → parity bit 1. 7O2 with 0x41 → 0,1,0,0,0,0,0,1,1,1,1 (parity 1).
- Three writes 0x55, 0xAA, 0x0F in consecutive clocks, 8N1 → 30 contiguous bit periods, no idle between frames, three `done_flag` pulses, `fifo_count` 3→0.
- `baud_tick` held low, 17 writes (FIFO_DEPTH=16) → `wr_ready` low after the 16th, `fifo_count`=16, 17th rejected. Restart ticks → exactly 16 frames sent, with the pointer wrap verified.
- `brk_req` high for 15 ticks while a frame with two more queued words is active → the current frame completes, line low for 15+ ticks, one mark period, then the queued words are sent.
- 9-bit mode, 0x1FF → nine 1 data bits; assert `reset_n`=0 mid-DATA → `data_tx`=1 and `fifo_count`=0 immediately.
